// File: rtl/fetch_if.sv
// Instruction-fetch port bundle: instruction bus request/response, decode handoff, redirect.
// No storage; pure wiring between fetch and its neighbours.
// Decode pushes back through stallD; the bus is valid/data_ok with a held request.
interface fetch_if;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        stall;
  } fetch_data_t;

  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stallD;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;

  // Fetch stage side
  modport master (
    output ireq,
    output dataF,
    input  iresp,
    input  stallD,
    input  redirect_valid,
    input  redirect_pc
  );

  // Memory / decode / redirect-source side
  modport slave (
    input  ireq,
    input  dataF,
    output iresp,
    output stallD,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, one outstanding bus request, registered handoff to decode.
// Latency: data_ok in cycle t gives a valid dataF in t+1; 1 instr/cycle with a same-cycle memory.
// Backpressure: stallD holds dataF; one extra instruction is parked in a skid buffer, then requests stop.
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master io_bus
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc_q, w_pc_nxt;
  logic [63:0] r_disc_addr, w_disc_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;
  logic [63:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_buf_instr, w_buf_instr_nxt;
  logic [63:0] r_buf_pc, w_buf_pc_nxt;

  logic        w_data_ok;
  logic [31:0] w_rdata;
  logic        w_stall_d;
  logic        w_redirect;
  logic [63:0] w_redirect_pc;
  logic        w_req_vld;
  logic [63:0] w_req_addr;
  logic        w_out_free;

  assign w_data_ok     = io_bus.iresp.data_ok;
  assign w_rdata       = io_bus.iresp.data;
  assign w_stall_d     = io_bus.stallD;
  assign w_redirect    = io_bus.redirect_valid;
  assign w_redirect_pc = io_bus.redirect_pc;

  // The output register can take new data if it is empty or decode takes it this edge.
  assign w_out_free = !r_out_valid || !w_stall_d;

  assign io_bus.ireq  = {w_req_vld, w_req_addr};
  assign io_bus.dataF = {r_out_instr, r_out_pc, ~r_out_valid};

  // Bus request: silent during reset and in HOLD; DISCARD keeps presenting the abandoned address.
  always_comb begin
    w_req_vld  = 1'b0;
    w_req_addr = r_pc_q;
    if (!reset) begin
      w_req_vld = (r_state != S_HOLD);
    end
    if (r_state == S_DISCARD) begin
      w_req_addr = r_disc_addr;
    end
  end

  // Next-state and datapath update; redirect outranks stallD and data_ok.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc_q;
    w_disc_nxt      = r_disc_addr;
    w_out_valid_nxt = r_out_valid && w_stall_d;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    w_buf_instr_nxt = r_buf_instr;
    w_buf_pc_nxt    = r_buf_pc;

    if (w_redirect) begin
      w_out_valid_nxt = 1'b0;
      w_pc_nxt        = w_redirect_pc;
      case (r_state)
        S_REQ: begin
          if (!w_data_ok) begin
            // Request still in flight: keep its address on the bus until it answers.
            w_state_nxt = S_DISCARD;
            w_disc_nxt  = r_pc_q;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_HOLD:    w_state_nxt = S_REQ;
        S_DISCARD: w_state_nxt = S_DISCARD;
        default:   w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_data_ok) begin
            w_pc_nxt = r_pc_q + 64'd4;
            if (w_out_free) begin
              w_out_valid_nxt = 1'b1;
              w_out_instr_nxt = w_rdata;
              w_out_pc_nxt    = r_pc_q;
            end else begin
              w_buf_instr_nxt = w_rdata;
              w_buf_pc_nxt    = r_pc_q;
              w_state_nxt     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!w_stall_d) begin
            w_out_valid_nxt = 1'b1;
            w_out_instr_nxt = r_buf_instr;
            w_out_pc_nxt    = r_buf_pc;
            w_state_nxt     = S_REQ;
          end
        end
        S_DISCARD: begin
          if (w_data_ok) begin
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, output register and skid buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_q      <= RESET_PC;
      r_disc_addr <= 64'd0;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_pc    <= 64'd0;
      r_buf_instr <= 32'd0;
      r_buf_pc    <= 64'd0;
    end else begin
      r_pc_q      <= w_pc_nxt;
      r_disc_addr <= w_disc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: behavioural instruction memory, decode consumer and an in-order scoreboard.
// Inputs change 1ns after the rising edge; everything is observed on the falling edge.
// Directed phases: reset/stream, slow memory, decode stall, redirects, reset while holding.
module tb_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_if bus();

  fetch #(.RESET_PC(RST_PC)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;

  // Memory model state
  int          epoch = 0;
  int          req_ep = 0;
  int          cnt = 0;
  int          mem_lat = 0;
  bit          busy = 1'b0;
  bit          mem_en = 1'b1;
  logic [63:0] req_addr = 64'd0;

  // Decode-side hold tracking
  bit          prev_hold = 1'b0;
  logic [63:0] prev_pc = 64'd0;
  logic [31:0] prev_instr = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle: decode consumption, memory response, redirect flush.
  task automatic settle();
    exp_t e;
    @(negedge clk);
    bus.iresp.data_ok = 1'b0;
    bus.iresp.data    = 32'd0;
    if (reset) begin
      sbq.delete();
      busy      = 1'b0;
      prev_hold = 1'b0;
      epoch++;
    end else begin
      if (prev_hold) begin
        chk("hold_stall", bus.dataF.stall, 0);
        chk("hold_pc", bus.dataF.pc, prev_pc);
        chk("hold_instr", bus.dataF.raw_instr, prev_instr);
      end
      if (!bus.dataF.stall && !bus.stallD) begin
        chk("sb_avail", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sb_pc", bus.dataF.pc, e.pc);
          chk("sb_instr", bus.dataF.raw_instr, e.instr);
        end
      end
      prev_hold  = !bus.dataF.stall && bus.stallD && !bus.redirect_valid;
      prev_pc    = bus.dataF.pc;
      prev_instr = bus.dataF.raw_instr;

      if (bus.ireq.valid) begin
        if (!busy) begin
          busy     = 1'b1;
          cnt      = 0;
          req_addr = bus.ireq.addr;
          req_ep   = epoch;
        end else begin
          chk("addr_stable", bus.ireq.addr, req_addr);
        end
        if (mem_en && cnt >= mem_lat) begin
          bus.iresp.data_ok = 1'b1;
          bus.iresp.data    = req_addr[31:0];
          busy              = 1'b0;
          if (req_ep == epoch && !bus.redirect_valid) begin
            e.pc    = req_addr;
            e.instr = req_addr[31:0];
            sbq.push_back(e);
          end
        end else begin
          cnt++;
        end
      end else if (busy) begin
        chk("valid_stable", bus.ireq.valid, 1);
      end

      if (bus.redirect_valid) begin
        sbq.delete();
        epoch++;
      end
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset              = 1'b1;
    bus.stallD         = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    for (int i = 0; i < n; i++) begin
      settle();
      chk("rst_req_valid", bus.ireq.valid, 0);
      edge_();
      chk("rst_stall", bus.dataF.stall, 1);
      chk("rst_instr", bus.dataF.raw_instr, 0);
      chk("rst_pc", bus.dataF.pc, 0);
    end
    reset = 1'b0;
  endtask

  // Stop responding and let decode take whatever is left; nothing may remain expected.
  task automatic drain();
    mem_en     = 1'b0;
    bus.stallD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      edge_();
    end
    chk("drain_empty", sbq.size(), 0);
    mem_en = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_addr;
    reset              = 1'b1;
    bus.stallD         = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    bus.iresp.data_ok  = 1'b0;
    bus.iresp.data     = 32'd0;

    // Reset then stream from a same-cycle memory
    do_reset(3);
    mem_lat  = 0;
    exp_addr = RST_PC;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("stream_valid", bus.ireq.valid, 1);
      chk("stream_addr", bus.ireq.addr, exp_addr);
      chk("stream_stall", bus.dataF.stall, (c == 0));
      exp_addr = exp_addr + 64'd4;
      edge_();
    end
    drain();

    // Slow memory: data_ok on the 4th cycle of each request
    do_reset(2);
    mem_lat = 3;
    for (int c = 0; c < 20; c++) begin
      settle();
      chk("slow_addr", bus.ireq.addr, RST_PC + 64'(4 * (c / 4)));
      chk("slow_stall", bus.dataF.stall, !(c > 0 && (c % 4) == 0));
      edge_();
    end
    mem_lat = 0;
    drain();

    // Decode back-pressure while 0x08 is presented and 0x0C arrives
    do_reset(2);
    for (int c = 0; c < 12; c++) begin
      bus.stallD = (c >= 3 && c <= 6);
      settle();
      if (c >= 3 && c <= 6) begin
        chk("bp_hold_pc", bus.dataF.pc, RST_PC + 64'h8);
      end
      if (c >= 4 && c <= 6) begin
        chk("bp_no_req", bus.ireq.valid, 0);
      end
      if (c == 8) chk("bp_pc_next", bus.dataF.pc, RST_PC + 64'hC);
      if (c == 9) chk("bp_pc_after", bus.dataF.pc, RST_PC + 64'h10);
      edge_();
    end
    drain();

    // Redirect while the request to 0x10 is outstanding
    do_reset(2);
    for (int c = 0; c < 14; c++) begin
      if (c == 4) mem_lat = 3;
      bus.redirect_valid = (c == 5);
      bus.redirect_pc    = (c == 5) ? 64'h8000_0100 : 64'd0;
      settle();
      if (c == 5) chk("rd_pending_addr", bus.ireq.addr, RST_PC + 64'h10);
      if (c == 6) chk("rd_discard_addr", bus.ireq.addr, RST_PC + 64'h10);
      if (c == 8) chk("rd_new_addr", bus.ireq.addr, 64'h8000_0100);
      if (c >= 6 && c <= 11) chk("rd_bubble", bus.dataF.stall, 1);
      if (c == 12) begin
        chk("rd_first_stall", bus.dataF.stall, 0);
        chk("rd_first_pc", bus.dataF.pc, 64'h8000_0100);
      end
      edge_();
    end
    bus.redirect_valid = 1'b0;
    mem_lat            = 0;
    drain();

    // Redirect on a data_ok cycle while decode is stalled
    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      bus.stallD         = (c == 2);
      bus.redirect_valid = (c == 2);
      bus.redirect_pc    = (c == 2) ? 64'h8000_0200 : 64'd0;
      settle();
      if (c == 2) chk("rdok_out_pc", bus.dataF.pc, RST_PC + 64'h4);
      if (c == 3) begin
        chk("rdok_flushed", bus.dataF.stall, 1);
        chk("rdok_valid", bus.ireq.valid, 1);
        chk("rdok_addr", bus.ireq.addr, 64'h8000_0200);
      end
      if (c == 4) begin
        chk("rdok_first_stall", bus.dataF.stall, 0);
        chk("rdok_first_pc", bus.dataF.pc, 64'h8000_0200);
        chk("rdok_first_instr", bus.dataF.raw_instr, 64'h8000_0200);
      end
      edge_();
    end
    bus.redirect_valid = 1'b0;
    drain();

    // Reset while parked in HOLD
    do_reset(2);
    for (int c = 0; c < 5; c++) begin
      bus.stallD = (c >= 3);
      settle();
      if (c == 4) chk("hrst_in_hold", bus.ireq.valid, 0);
      edge_();
    end
    do_reset(1);
    exp_addr = RST_PC;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("hrst_valid", bus.ireq.valid, 1);
      chk("hrst_addr", bus.ireq.addr, exp_addr);
      exp_addr = exp_addr + 64'd4;
      edge_();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the lab3 pipeline, directly upstream of decode. It owns the PC and issues one request at a time on the instruction bus. Each returned instruction is registered into a `fetch_data_t` record (`raw_instr`, `pc`, `stall`) for decode. It also handles back-pressure from decode and PC redirects from later stages.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC fetched first after reset.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high reset.
- `ireq`  out  `ibus_req_t`  fields:
  - `valid` (1): request pending.
  - `addr` (64): fetch address.
- `iresp`  in  `ibus_resp_t`  fields:
  - `data_ok` (1): response valid this cycle, same-cycle with `valid`.
  - `data` (32): instruction word.
- `stallD`  in  1  decode cannot accept; hold `dataF`.
- `redirect_valid`  in  1  later stage demands a PC change this cycle.
- `redirect_pc`  in  64  new PC; used only when `redirect_valid`.
- `dataF`  out  `fetch_data_t`  fields:
  - `raw_instr` (32).
  - `pc` (64).
  - `stall` (1): 1 = bubble, no valid instruction.

## Operation
- **State:**
  - `pc_q` (64).
  - Output register `out_valid`/`out_instr`/`out_pc`.
  - Skid buffer `buf_instr`/`buf_pc`.
  - FSM `{REQ, HOLD, DISCARD}`.
- **Outputs:**
  - `dataF.stall = ~out_valid`.
  - `dataF.raw_instr = out_instr`.
  - `dataF.pc = out_pc`.
  - `ireq.addr = pc_q` in REQ. In DISCARD it is the held address of the outstanding request.
- **Output register:**
  - Consumed at the clock edge when `out_valid && !stallD`.
  - Clears to a bubble when consumed and not reloaded that edge.
- **REQ:**
  - `ireq.valid = 1`.
  - On `data_ok` with no redirect, `pc_q <= pc_q + 4` (64-bit, wraps modulo 2^64).
  - If the output register is free or being consumed, load `{data, pc_q}` into it and stay in REQ.
  - Otherwise (`out_valid && stallD`), store `{data, pc_q}` into the skid buffer and go to HOLD.
- **HOLD:**
  - `ireq.valid = 0`.
  - When `!stallD`, move the buffer into the output register and go to REQ.
- **DISCARD:**
  - `ireq.valid = 1`; the address stays frozen at the value from the redirect cycle.
  - On `data_ok`, drop the data and go to REQ.
- **Redirect:** `redirect_valid` has priority over `stallD` and `data_ok`. On the next edge:
  - `out_valid <= 0` and the skid buffer is dropped.
  - `pc_q <= redirect_pc`.
  - Next state:
    - from REQ with no `data_ok` this cycle → DISCARD;
    - from REQ with `data_ok` this cycle → REQ (data dropped);
    - from HOLD → REQ;
    - from DISCARD → stays DISCARD; the newest redirect overwrites `pc_q`.
- **Bus rule:** once `ireq.valid` rises, `valid` and `addr` stay stable until `data_ok` is sampled. Reset is the only exception.
- **Alignment:** no alignment check; `redirect_pc` is used as given.

## Timing
- **Reset values:**
  - `pc_q = RESET_PC`, state REQ.
  - `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, so `dataF.stall = 1`.
  - `ireq.valid = 0` in the reset cycle and 1 from the first cycle after reset deasserts.
- **Reset mid-request:** abandons the outstanding request with no DISCARD.
- **Latency:** `data_ok` in cycle t → `dataF` valid in t+1.
- **Throughput:** next request address `pc+4` appears in t+1. With a same-cycle-responding memory, sustained throughput is 1 instruction/cycle.
- **Back-pressure:** with `stallD` held, `dataF` stays constant. At most one further instruction is absorbed (HOLD), and no request is issued in HOLD.
- **Redirect to decode:** the first post-redirect instruction appears at the earliest 2 cycles after `redirect_valid` (REQ case with `data_ok` in the redirect cycle).
- **Stale-response rule:** a response for a request issued before a redirect never reaches `dataF`.

## Test plan
- **Reset and streaming:**
  - Stimulus: reset 3 cycles; memory returns `data_ok` every cycle with `data = addr[31:0]`.
  - Required: `ireq.addr` sequence is 0x8000_0000, 0x8000_0004, … with no gaps; `dataF.pc` lags by 1 cycle; `stall = 0` from cycle 2 on.
- **Slow memory:**
  - Stimulus: `data_ok` 3 cycles after `valid`.
  - Required: `addr` stable for all 3 cycles; one bubble pattern per instruction; `dataF.pc` increments by 4.
- **Decode back-pressure:**
  - Stimulus: `stallD = 1` for 4 cycles while instructions at 0x8000_0008/0x8000_000C arrive.
  - Required: `dataF` holds 0x8000_0008; `ireq.valid = 0` once HOLD is entered; after release, 0x8000_000C then 0x8000_0010 appear with no loss or duplication.
- **Redirect during outstanding request:**
  - Stimulus: `redirect_valid` with `redirect_pc = 0x8000_0100` while a request to 0x8000_0010 is pending.
  - Required: the 0x8000_0010 data is dropped; the next `addr` is 0x8000_0100; `dataF.stall = 1` until that instruction returns.
- **Redirect on the `data_ok` cycle, combined with `stallD = 1`:**
  - Required: returned data dropped; output flushed; next request goes to the redirect PC one cycle later.
- **Mid-HOLD reset:**
  - Required: all outputs return to reset values; the fetch restarts at `RESET_PC`.
